lutram_bist: RTL and testbench

- Parametrised, self-checking successor to the single-bit LUTRAM primitive test.
- Drives a distributed-RAM array of 2**A_WIDTH x D_WIDTH through a full test: clear, pattern write, read-back compare.
- Reports pass/fail, an error count and the first failing address, so a board run needs no scope on q_o.
- Runs on a single clock; a clock-enable tick paces the sequence instead of a derived divided clock.

---
 rtl/lutram_bist_pkg.sv | 30 +++
 rtl/lutram_bist_mem.sv | 23 ++
 rtl/lutram_bist.sv | 147 ++++++++++++++
 tb/tb_lutram_bist.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lutram_bist_pkg.sv
// Shared state encoding, pattern-mode constants and the expected-data function
// used by the distributed-RAM built-in self test.
package lutram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_CHECKER = 2'd0;
  localparam logic [1:0] MODE_ADDR    = 2'd1;
  localparam logic [1:0] MODE_ONES    = 2'd2;
  localparam logic [1:0] MODE_NADDR   = 2'd3;

  // Result is 8 bits wide; callers truncate on the MSB side to their data width.
  function automatic logic [7:0] pattern(input logic [1:0] mode, input logic [7:0] addr);
    logic [7:0] res;
    case (mode)
      MODE_CHECKER: res = {8{addr[0]}};
      MODE_ADDR:    res = addr;
      MODE_ONES:    res = 8'hFF;
      default:      res = ~addr;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lutram_bist_mem.sv
// Distributed RAM under test: synchronous write, asynchronous read.
module lutram_bist_mem
  import lutram_bist_pkg::*;
#(
  parameter int A_WIDTH = 7,
  parameter int D_WIDTH = 1
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] addr_i,
  input  logic [D_WIDTH-1:0] d_i,
  output logic [D_WIDTH-1:0] q_o
);

  (* ram_style = "distributed" *) logic [D_WIDTH-1:0] mem_q [2**A_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= d_i;
  end

  assign q_o = mem_q[addr_i];

endmodule

// File: rtl/lutram_bist.sv
// Self-checking LUTRAM test: clears the array, writes a selectable pattern,
// reads it back and reports pass/fail, a saturating error count and first bad address.
module lutram_bist
  import lutram_bist_pkg::*;
#(
  parameter int          A_WIDTH         = 7,
  parameter int          D_WIDTH         = 1,
  parameter logic [31:0] DIV_COUNTER_END = 32'h00FF_FFFF,
  parameter int          E_WIDTH         = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic               fault_i,
  output logic [D_WIDTH-1:0] q_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [E_WIDTH-1:0] err_cnt_o,
  output logic [A_WIDTH-1:0] err_addr_o
);

  localparam logic [A_WIDTH-1:0] ADDR_MAX = '1;

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]        div_q;
  logic               tick_q;
  logic [E_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [A_WIDTH-1:0] err_addr_q, err_addr_d;
  logic               first_q, first_d;
  logic [1:0]         mode_q, mode_d;
  logic               we;
  logic [D_WIDTH-1:0] wdata;
  logic [D_WIDTH-1:0] exp_data;
  logic [D_WIDTH-1:0] rdata;

  // Step pacing: one-clock tick every DIV_COUNTER_END+1 clocks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= 32'd0;
      tick_q <= 1'b0;
    end else if (div_q >= DIV_COUNTER_END) begin
      div_q  <= 32'd0;
      tick_q <= 1'b1;
    end else begin
      div_q  <= div_q + 32'd1;
      tick_q <= 1'b0;
    end
  end

  assign exp_data = D_WIDTH'(pattern(mode_q, 8'(addr_q)));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    first_d    = first_q;
    mode_d     = mode_q;
    we         = 1'b0;
    wdata      = '0;
    case (state_q)
      IDLE, DONE: begin
        if (tick_q && start_i) begin
          mode_d     = mode_i;
          err_cnt_d  = '0;
          err_addr_d = '0;
          first_d    = 1'b0;
          addr_d     = '0;
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        we = 1'b1;
        if (tick_q) begin
          addr_d = addr_q + A_WIDTH'(1);
          if (addr_q == ADDR_MAX) state_d = WRITE;
        end
      end
      WRITE: begin
        we    = 1'b1;
        wdata = exp_data ^ D_WIDTH'(fault_i);
        if (tick_q) begin
          addr_d = addr_q + A_WIDTH'(1);
          if (addr_q == ADDR_MAX) state_d = READ;
        end
      end
      READ: begin
        if (tick_q) begin
          // Read is asynchronous, so the data for addr_q is valid in this clock.
          if (rdata != exp_data) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + E_WIDTH'(1);
            if (!first_q) begin
              err_addr_d = addr_q;
              first_d    = 1'b1;
            end
          end
          addr_d = addr_q + A_WIDTH'(1);
          if (addr_q == ADDR_MAX) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      first_q    <= 1'b0;
      mode_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      first_q    <= first_d;
      mode_q     <= mode_d;
    end
  end

`ifdef YOSYS
  (* keep *)
`endif
  lutram_bist_mem #(
    .A_WIDTH(A_WIDTH),
    .D_WIDTH(D_WIDTH)
  ) u_mem (
    .clk_i (clk_i),
    .we_i  (we & tick_q),
    .addr_i(addr_q),
    .d_i   (wdata),
    .q_o   (rdata)
  );

  assign q_o        = rdata;
  assign busy_o     = (state_q == CLEAR) || (state_q == WRITE) || (state_q == READ);
  assign done_o     = (state_q == DONE);
  assign pass_o     = done_o && (err_cnt_q == '0);
  assign err_cnt_o  = err_cnt_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_lutram_bist.sv
// Bench for lutram_bist: a run-level reference model for the main instance plus
// directed runs on a small-error-counter instance and a slow-tick instance.
module tb_lutram_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b, start_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic fault_a, fault_b, fault_c;

  logic [3:0]  q_a, q_b, q_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [15:0] err_a, err_c;
  logic [2:0]  err_b;
  logic [3:0]  eaddr_a, eaddr_b, eaddr_c;

  lutram_bist #(.A_WIDTH(4), .D_WIDTH(4), .DIV_COUNTER_END(32'd0), .E_WIDTH(16)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .mode_i(mode_a), .fault_i(fault_a),
    .q_o(q_a), .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .err_cnt_o(err_a), .err_addr_o(eaddr_a));

  lutram_bist #(.A_WIDTH(4), .D_WIDTH(4), .DIV_COUNTER_END(32'd0), .E_WIDTH(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .mode_i(mode_b), .fault_i(fault_b),
    .q_o(q_b), .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .err_cnt_o(err_b), .err_addr_o(eaddr_b));

  lutram_bist #(.A_WIDTH(4), .D_WIDTH(4), .DIV_COUNTER_END(32'd3), .E_WIDTH(16)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_c), .mode_i(mode_c), .fault_i(fault_c),
    .q_o(q_c), .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c),
    .err_cnt_o(err_c), .err_addr_o(eaddr_c));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_pat(input logic [1:0] m, input int a);
    case (m)
      2'd0:    return (a % 2 == 1) ? 4'hF : 4'h0;
      2'd1:    return 4'(a);
      2'd2:    return 4'hF;
      default: return 4'(15 - (a % 16));
    endcase
  endfunction

  // Reference for instance A: a run is 48 ticks (16 clear, 16 write, 16 read).
  bit         m_tick, m_busy, m_done, m_first;
  int         m_k, m_err, m_eaddr;
  logic [1:0] m_mode;
  logic [3:0] m_ram [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tick <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_first <= 1'b0;
      m_k <= 0; m_err <= 0; m_eaddr <= 0; m_mode <= 2'd0;
    end else begin
      if (m_tick) begin
        if (!m_busy) begin
          if (start_a) begin
            m_busy <= 1'b1; m_done <= 1'b0; m_k <= 0; m_err <= 0;
            m_eaddr <= 0; m_first <= 1'b0; m_mode <= mode_a;
          end
        end else begin
          if (m_k < 16) m_ram[m_k % 16] <= 4'h0;
          else if (m_k < 32) m_ram[m_k % 16] <= ref_pat(m_mode, m_k % 16) ^ {3'b000, fault_a};
          else if (m_ram[m_k % 16] !== ref_pat(m_mode, m_k % 16)) begin
            m_err <= m_err + 1;
            if (!m_first) begin
              m_first <= 1'b1;
              m_eaddr <= m_k % 16;
            end
          end
          m_k <= m_k + 1;
          if (m_k == 47) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
          end
        end
      end
      // Divider end of 0: every clock after the first post-reset clock is a tick.
      m_tick <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy", 32'(busy_a), 32'(m_busy));
      chk("done", 32'(done_a), 32'(m_done));
      chk("pass", 32'(pass_a), 32'(m_done && m_err == 0));
      chk("err_cnt", 32'(err_a), 32'(m_err));
      chk("err_addr", 32'(eaddr_a), 32'(m_eaddr));
      if (m_busy && m_k >= 32) chk("q_read", 32'(q_a), 32'(m_ram[m_k % 16]));
    end
  end

  task automatic start_a_run(input logic [1:0] m);
    mode_a  = m;
    start_a = 1'b1;
    for (int i = 0; i < 8 && !busy_a; i++) @(negedge clk);
    start_a = 1'b0;
    chk("start_a", 32'(busy_a), 32'd1);
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 200 && !done_a; i++) @(negedge clk);
    chk("done_a_timeout", 32'(done_a), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int gaps;
    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mode_a = 2'd0; mode_b = 2'd0; mode_c = 2'd0;
    fault_a = 1'b0; fault_b = 1'b0; fault_c = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_eaddr", 32'(eaddr_a), 32'd0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // Clean address-pattern run; busy must last exactly 48 ticks.
    start_a_run(2'd1);
    n = 1;
    for (int i = 0; i < 100 && busy_a; i++) begin
      @(negedge clk);
      if (busy_a) n++;
    end
    chk("busy_len", 32'(n), 32'd48);
    chk("t1_done", 32'(done_a), 32'd1);
    chk("t1_pass", 32'(pass_a), 32'd1);
    chk("t1_err", 32'(err_a), 32'd0);
    chk("t1_eaddr", 32'(eaddr_a), 32'd0);

    // Fault held for the whole run: every read differs in bit 0.
    fault_a = 1'b1;
    start_a_run(2'd1);
    wait_done_a();
    fault_a = 1'b0;
    chk("t2_err", 32'(err_a), 32'd16);
    chk("t2_model_err", 32'(m_err), 32'd16);
    chk("t2_eaddr", 32'(eaddr_a), 32'd0);
    chk("t2_pass", 32'(pass_a), 32'd0);

    // Checkerboard with a single corrupted write at address 5.
    start_a_run(2'd0);
    repeat (21) @(negedge clk);
    fault_a = 1'b1;
    @(negedge clk);
    fault_a = 1'b0;
    wait_done_a();
    chk("t3_err", 32'(err_a), 32'd1);
    chk("t3_eaddr", 32'(eaddr_a), 32'd5);
    chk("t3_model_eaddr", 32'(m_eaddr), 32'd5);
    chk("t3_pass", 32'(pass_a), 32'd0);

    // Inverted-address pattern restarted from DONE clears old results.
    start_a_run(2'd3);
    wait_done_a();
    chk("t4_pass", 32'(pass_a), 32'd1);
    chk("t4_err", 32'(err_a), 32'd0);

    // Three-bit error counter must saturate at 7.
    fault_b = 1'b1;
    mode_b  = 2'd1;
    start_b = 1'b1;
    for (int i = 0; i < 8 && !busy_b; i++) @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 200 && !done_b; i++) @(negedge clk);
    fault_b = 1'b0;
    chk("b_done", 32'(done_b), 32'd1);
    chk("b_err_sat", 32'(err_b), 32'd7);
    chk("b_eaddr", 32'(eaddr_b), 32'd0);
    chk("b_pass", 32'(pass_b), 32'd0);

    // Slow tick: a run takes 4*48 clocks from the start edge.
    mode_c  = 2'd1;
    start_c = 1'b1;
    for (int i = 0; i < 20 && !busy_c; i++) @(negedge clk);
    start_c = 1'b0;
    chk("c_start", 32'(busy_c), 32'd1);
    n = 0;
    gaps = 0;
    for (int i = 0; i < 400 && !done_c; i++) begin
      @(negedge clk);
      n++;
      if (!done_c && !busy_c) gaps++;
    end
    chk("c_latency", 32'(n), 32'd192);
    chk("c_busy_gaps", 32'(gaps), 32'd0);
    chk("c_pass", 32'(pass_c), 32'd1);
    chk("c_err", 32'(err_c), 32'd0);

    // Reset pulse in the middle of READ, then a fresh all-ones run.
    start_a_run(2'd1);
    repeat (38) @(negedge clk);
    chk("pre_rst_busy", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_done", 32'(done_a), 32'd0);
    chk("midrst_pass", 32'(pass_a), 32'd0);
    chk("midrst_err", 32'(err_a), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    start_a_run(2'd2);
    wait_done_a();
    chk("t5_pass", 32'(pass_a), 32'd1);
    chk("t5_err", 32'(err_a), 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
